reg_list_sequencer: RTL and testbench

- Multi-cycle block-transfer engine for LDM/STM-style instructions.
- Initiator side of the 16-entry register file: walks a 16-bit register list and drives register-file read/write ports and a word-wide data-memory port.
- Sits between decode/control and the register file. The core stalls while `busy` is high.

---
 rtl/reg_list_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_reg_list_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_list_sequencer.sv
// rtl/reg_list_sequencer.sv - LDM/STM block-transfer sequencer (optional abort: REGSEQ_ABORT_EN)
module reg_list_sequencer #(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre_idx,
    input  logic              up,
    input  logic              wback,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_val,
    input  logic [NREGS-1:0]  reg_list,
    output logic [3:0]        rf_read_reg,
    input  logic [ADDR_W-1:0] rf_read_data,
    output logic [3:0]        rf_write_reg,
    output logic [ADDR_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_ready,
`ifdef REGSEQ_ABORT_EN
    input  logic              mem_abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(NREGS + 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               is_load_q, is_load_d;
    logic               wback_q, wback_d;
    logic               wb_write_q, wb_write_d;
    logic [3:0]         base_reg_q, base_reg_d;
    logic [NREGS-1:0]   list_q, list_d;
    logic [ADDR_W-1:0]  cursor_q, cursor_d;
    logic [ADDR_W-1:0]  final_q, final_d;

    logic [CNT_W-1:0]   n_regs;
    logic [ADDR_W-1:0]  span;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  final_addr;
    logic [NREGS-1:0]   cur_onehot;
    logic [NREGS-1:0]   list_rem;
    logic [3:0]         cur_idx;
    logic               abort_w;

`ifdef REGSEQ_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_w = mem_abort;
`else
    assign abort_w = 1'b0;
`endif

    // Count the requested registers and derive the address window at start.
    always_comb begin
        n_regs = '0;
        for (int i = 0; i < NREGS; i++) begin
            n_regs = n_regs + CNT_W'(reg_list[i]);
        end
        span = {{(ADDR_W-CNT_W-2){1'b0}}, n_regs, 2'b00};
        if (up) begin
            start_addr = pre_idx ? base_val + ADDR_W'(4) : base_val;
            final_addr = base_val + span;
        end else begin
            start_addr = pre_idx ? base_val - span : base_val - span + ADDR_W'(4);
            final_addr = base_val - span;
        end
    end

    // Pick the lowest remaining register; the list is always walked upward.
    always_comb begin
        cur_onehot = list_q & (~list_q + NREGS'(1));
        list_rem   = list_q & ~cur_onehot;
        cur_idx    = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (list_q[i]) cur_idx = 4'(i);
        end
    end

    // State and latched transfer context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_load_q  <= 1'b0;
            wback_q    <= 1'b0;
            wb_write_q <= 1'b0;
            base_reg_q <= '0;
            list_q     <= '0;
            cursor_q   <= '0;
            final_q    <= '0;
`ifdef REGSEQ_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            wback_q    <= wback_d;
            wb_write_q <= wb_write_d;
            base_reg_q <= base_reg_d;
            list_q     <= list_d;
            cursor_q   <= cursor_d;
            final_q    <= final_d;
`ifdef REGSEQ_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    // Next-state: latch on start, advance the cursor on each completed beat.
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        wback_d    = wback_q;
        wb_write_d = wb_write_q;
        base_reg_d = base_reg_q;
        list_d     = list_q;
        cursor_d   = cursor_q;
        final_d    = final_q;
`ifdef REGSEQ_ABORT_EN
        aborted_d  = aborted_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_load_d  = is_load;
                    wback_d    = wback;
                    // A loaded base register keeps its loaded value; R15 is never a base target.
                    wb_write_d = !((is_load && reg_list[base_reg]) || (base_reg == 4'd15));
                    base_reg_d = base_reg;
                    list_d     = reg_list;
                    cursor_d   = start_addr;
                    final_d    = final_addr;
`ifdef REGSEQ_ABORT_EN
                    aborted_d  = 1'b0;
`endif
                    state_d    = (n_regs == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (abort_w) begin
`ifdef REGSEQ_ABORT_EN
                    aborted_d = 1'b1;
`endif
                    state_d   = S_DONE;
                end else if (mem_ready) begin
                    list_d   = list_rem;
                    cursor_d = cursor_q + ADDR_W'(4);
                    if (list_rem == '0) begin
                        state_d = wback_q ? S_WB : S_DONE;
                    end
                end
            end
            S_WB:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from state so reset forces them all low at once.
    always_comb begin
        rf_read_reg   = '0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_reg_write  = 1'b0;
        pc_load       = 1'b0;
        pc_load_data  = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
`ifdef REGSEQ_ABORT_EN
        aborted       = 1'b0;
`endif
        case (state_q)
            S_XFER: begin
                mem_req  = 1'b1;
                mem_we   = !is_load_q;
                mem_addr = {cursor_q[ADDR_W-1:2], 2'b00};
                if (!is_load_q) begin
                    rf_read_reg = cur_idx;
                    mem_wdata   = rf_read_data;
                end else if (mem_ready && !abort_w) begin
                    rf_write_reg  = cur_idx;
                    rf_write_data = mem_rdata;
                    if (cur_idx == 4'd15) begin
                        pc_load      = 1'b1;
                        pc_load_data = mem_rdata;
                    end else begin
                        rf_reg_write = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_write_reg  = base_reg_q;
                rf_write_data = final_q;
                rf_reg_write  = wb_write_q;
            end
            S_DONE: begin
                done = 1'b1;
`ifdef REGSEQ_ABORT_EN
                aborted = aborted_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// tb/tb_reg_list_sequencer.sv - self-checking bench for reg_list_sequencer
module tb_reg_list_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, pre_idx, up, wback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic [3:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic [3:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rf_reg_write, pc_load;
    logic [31:0] pc_load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        mem_abort;
    logic        aborted;
    logic        busy, done;

    logic [31:0] rf_mem [16];

    always #5 clk = ~clk;

    assign rf_read_data = (rf_read_reg == 4'd15) ? rf_mem[15] + 32'd8 : rf_mem[rf_read_reg];

    reg_list_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .pre_idx(pre_idx),
        .up(up), .wback(wback), .base_reg(base_reg), .base_val(base_val),
        .reg_list(reg_list), .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_reg_write(rf_reg_write), .pc_load(pc_load), .pc_load_data(pc_load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef REGSEQ_ABORT_EN
        .mem_abort(mem_abort), .aborted(aborted),
`endif
        .busy(busy), .done(done)
    );

`ifndef REGSEQ_ABORT_EN
    assign aborted = 1'b0;
`endif

    typedef struct {
        logic        is_load, pre, up, wback;
        logic [3:0]  br;
        logic [31:0] base;
        logic [15:0] list;
        int          waits;
        logic [31:0] exp_first;
        int          exp_done;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic fill_rf(input bit rnd);
        for (int i = 0; i < 16; i++) rf_mem[i] = rnd ? $urandom : (32'hA000_0000 | (i << 8) | i);
    endtask

    // Drives one instruction and checks every cycle against a list-level model.
    task automatic run_seq(input vec_t v, input int abort_beat,
                           output logic [31:0] first_addr, output int done_cyc);
        int          n, k, cyc, waits;
        logic [31:0] sa, fin;
        logic [31:0] eaddr [16];
        logic [3:0]  ereg [16];
        logic        was_aborted, last, ab, wr, wb_write;
        n   = $countones(v.list);
        fin = v.up ? v.base + 32'(4 * n) : v.base - 32'(4 * n);
        if (v.up) sa = v.pre ? v.base + 32'd4 : v.base;
        else      sa = v.pre ? v.base - 32'(4 * n) : v.base - 32'(4 * n) + 32'd4;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (v.list[i]) begin
                eaddr[k] = sa + 32'(4 * k);
                ereg[k]  = 4'(i);
                k++;
            end
        end
        wb_write   = !((v.is_load && v.list[v.br]) || v.br == 4'd15);
        first_addr = '0;
        was_aborted = 1'b0;

        @(negedge clk);
        start = 1'b1; is_load = v.is_load; pre_idx = v.pre; up = v.up; wback = v.wback;
        base_reg = v.br; base_val = v.base; reg_list = v.list;
        #1 chk("idle_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        is_load = $urandom; pre_idx = $urandom; up = $urandom; wback = $urandom;
        base_reg = $urandom; base_val = $urandom; reg_list = $urandom;
        cyc = 1;
        for (int b = 0; b < n && !was_aborted; b++) begin
            waits = (v.waits >= 0) ? v.waits : $urandom_range(0, 2);
            for (int w = 0; w <= waits; w++) begin
                last = (w == waits);
                ab   = last && (b == abort_beat);
                mem_ready = last;
                mem_abort = ab;
                mem_rdata = last ? mem_word(eaddr[b]) : $urandom;
                #1;
                if (b == 0 && w == 0) first_addr = mem_addr;
                chk("mem_req", mem_req, 1'b1);
                chk("mem_addr", mem_addr, eaddr[b]);
                chk("mem_we", mem_we, !v.is_load);
                chk("busy_xfer", busy, 1'b1);
                chk("done_xfer", done, 1'b0);
                if (!v.is_load) begin
                    chk("rf_read_reg", rf_read_reg, ereg[b]);
                    chk("mem_wdata", mem_wdata,
                        (ereg[b] == 4'd15) ? rf_mem[15] + 32'd8 : rf_mem[ereg[b]]);
                    chk("st_no_write", rf_reg_write | pc_load, 1'b0);
                end else begin
                    wr = last && !ab;
                    chk("ld_write", rf_reg_write, wr && ereg[b] != 4'd15);
                    chk("ld_pc_load", pc_load, wr && ereg[b] == 4'd15);
                    if (wr && ereg[b] != 4'd15) begin
                        chk("ld_reg", rf_write_reg, ereg[b]);
                        chk("ld_data", rf_write_data, mem_word(eaddr[b]));
                    end
                    if (wr && ereg[b] == 4'd15) chk("pc_data", pc_load_data, mem_word(eaddr[b]));
                end
                @(negedge clk);
                cyc++;
                if (ab) was_aborted = 1'b1;
            end
        end
        mem_ready = 1'b0;
        mem_abort = 1'b0;
        if (v.wback && n > 0 && !was_aborted) begin
            #1;
            chk("wb_no_mem", mem_req, 1'b0);
            chk("wb_busy", busy, 1'b1);
            chk("wb_write", rf_reg_write, wb_write);
            chk("wb_pc_load", pc_load, 1'b0);
            if (wb_write) begin
                chk("wb_reg", rf_write_reg, v.br);
                chk("wb_data", rf_write_data, fin);
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("done", done, 1'b1);
        chk("done_no_mem", mem_req, 1'b0);
        chk("done_no_write", rf_reg_write, 1'b0);
`ifdef REGSEQ_ABORT_EN
        chk("aborted", aborted, was_aborted);
`endif
        done_cyc = cyc;
        @(negedge clk);
        #1;
        chk("post_busy", busy, 1'b0);
        chk("post_done", done, 1'b0);
    endtask

    vec_t        tbl [7];
    vec_t        v;
    logic [31:0] fa;
    int          dc;

    initial begin
        rst = 1'b1; start = 0; is_load = 0; pre_idx = 0; up = 0; wback = 0;
        base_reg = 0; base_val = 0; reg_list = 0; mem_rdata = 0; mem_ready = 0; mem_abort = 0;
        fill_rf(1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rf_write", rf_reg_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        //            ld pre up wb  br     base           list      waits first         done
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  32'h0000_0100, 16'h000F, 0, 32'h0000_0100, 6};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  32'h0000_0200, 16'h8011, 0, 32'h0000_01F4, 4};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0000_0040, 16'h0006, 2, 32'h0000_0040, 8};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  32'h0000_0800, 16'h0000, 0, 32'h0000_0000, 1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 32'h0000_1000, 16'h8001, 0, 32'h0000_1004, 4};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  32'h0000_0080, 16'h00F0, 0, 32'h0000_0074, 6};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  32'hFFFF_FFFC, 16'h0003, 1, 32'h0000_0000, 6};
        for (int i = 0; i < 7; i++) begin
            run_seq(tbl[i], -1, fa, dc);
            chk($sformatf("first_addr[%0d]", i), fa, tbl[i].exp_first);
            chk($sformatf("done_cycle[%0d]", i), dc, tbl[i].exp_done);
        end

        // Reset in the middle of an STM after two of four beats.
        @(negedge clk);
        start = 1; is_load = 0; pre_idx = 0; up = 1; wback = 1;
        base_reg = 4'd1; base_val = 32'h300; reg_list = 16'h000F;
        @(negedge clk);
        start = 0; mem_ready = 1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid_addr", mem_addr, 32'h308);
        rst = 1'b1;
        #1;
        chk("arst_mem_req", mem_req, 1'b0);
        chk("arst_mem_we", mem_we, 1'b0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        chk("arst_rd_reg", rf_read_reg, 4'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_write", rf_reg_write, 1'b0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 0;
        v = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h300, 16'h000F, 0, 32'h300, 6};
        run_seq(v, -1, fa, dc);
        chk("post_rst_done_cycle", dc, 6);

`ifdef REGSEQ_ABORT_EN
        v = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 32'h500, 16'h0007, 0, 32'h504, 3};
        run_seq(v, 1, fa, dc);
        chk("abort_first", fa, 32'h504);
        chk("abort_done_cycle", dc, 3);
`endif

        // Randomized instructions against the list-level model.
        for (int r = 0; r < 40; r++) begin
            fill_rf(1'b1);
            v.is_load = $urandom; v.pre = $urandom; v.up = $urandom; v.wback = $urandom;
            v.br      = $urandom;
            v.base    = $urandom & 32'hFFFF_FFFC;
            v.list    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            v.waits   = -1;
            v.exp_first = 0;
            v.exp_done  = 0;
`ifdef REGSEQ_ABORT_EN
            run_seq(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, fa, dc);
`else
            run_seq(v, -1, fa, dc);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
